// File: rtl/hdmi_tx_cfg_sequencer.sv
// HDMI transmitter bring-up: hardware reset pulse, power-up wait, then a ROM table of register writes over I2C.
// Outputs are registered from next state; each write holds i2c_req until the master answers with ack or nack.
module hdmi_tx_cfg_sequencer #(
  parameter logic [6:0] SLAVE_ADDR        = 7'h39,
  parameter int         NUM_REGS          = 16,
  parameter int         RST_HOLD_CYCLES   = 1000,
  parameter int         PWRUP_WAIT_CYCLES = 2000000,
  parameter int         RETRY_MAX         = 3,
  parameter bit         AUTO_START        = 1'b1
) (
  input  logic        clk_100m,
  input  logic        rst,
  input  logic        start,
  input  logic        hdmi_int_n,
  output logic        hdmi_tx_rst_n,
  output logic [7:0]  tbl_addr,
  input  logic [15:0] tbl_data,
  output logic        i2c_req,
  output logic [6:0]  i2c_dev_addr,
  output logic [7:0]  i2c_reg,
  output logic [7:0]  i2c_wdata,
  input  logic        i2c_ack,
  input  logic        i2c_nack,
  output logic        video_en,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RST_ASSERT,
    ST_PWRUP_WAIT,
    ST_FETCH,
    ST_LATCH,
    ST_WRITE,
    ST_RETRY,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam logic [31:0] RST_LAST   = 32'(RST_HOLD_CYCLES - 1);
  localparam logic [31:0] PWRUP_LAST = 32'(PWRUP_WAIT_CYCLES - 1);
  localparam logic [7:0]  IDX_LAST   = 8'(NUM_REGS - 1);
  localparam logic [3:0]  RETRY_LIM  = 4'(RETRY_MAX);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  idx_q, idx_d;
  logic [3:0]  retry_q, retry_d;
  logic        hpd_pending_q, hpd_pending_d;
  logic        hpd_meta_q, hpd_meta_d;
  logic        hpd_sync_q, hpd_sync_d;
  logic        hpd_prev_q, hpd_prev_d;
  logic        hdmi_tx_rst_n_q, hdmi_tx_rst_n_d;
  logic [7:0]  tbl_addr_q, tbl_addr_d;
  logic        i2c_req_q, i2c_req_d;
  logic [7:0]  i2c_reg_q, i2c_reg_d;
  logic [7:0]  i2c_wdata_q, i2c_wdata_d;
  logic        video_en_q, video_en_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic hpd_evt;
  logic in_busy;

  // Falling edge of the synchronized interrupt is the hot-plug event.
  assign hpd_evt = hpd_prev_q & ~hpd_sync_q;
  assign in_busy = (state_q inside {ST_RST_ASSERT, ST_PWRUP_WAIT, ST_FETCH,
                                    ST_LATCH, ST_WRITE, ST_RETRY});

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    retry_d       = retry_q;
    hpd_pending_d = hpd_pending_q | (hpd_evt & in_busy);
    i2c_reg_d     = i2c_reg_q;
    i2c_wdata_d   = i2c_wdata_q;
    tbl_addr_d    = tbl_addr_q;
    hpd_meta_d    = hdmi_int_n;
    hpd_sync_d    = hpd_meta_q;
    hpd_prev_d    = hpd_sync_q;

    case (state_q)
      ST_IDLE: begin
        if (AUTO_START || start) begin
          state_d       = ST_RST_ASSERT;
          cnt_d         = '0;
          hpd_pending_d = 1'b0;
        end
      end
      ST_RST_ASSERT: begin
        if (cnt_q == RST_LAST) begin
          state_d = ST_PWRUP_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_PWRUP_WAIT: begin
        if (cnt_q == PWRUP_LAST) begin
          state_d = ST_FETCH;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_FETCH: begin
        state_d = ST_LATCH;
      end
      ST_LATCH: begin
        i2c_reg_d   = tbl_data[15:8];
        i2c_wdata_d = tbl_data[7:0];
        retry_d     = '0;
        state_d     = ST_WRITE;
      end
      ST_WRITE: begin
        // nack takes priority so a glitchy double response is retried.
        if (i2c_nack) begin
          if (retry_q < RETRY_LIM) begin
            retry_d = retry_q + 4'd1;
            state_d = ST_RETRY;
          end else begin
            state_d = ST_ERROR;
          end
        end else if (i2c_ack) begin
          if (idx_q == IDX_LAST) begin
            if (hpd_pending_q || hpd_evt) begin
              state_d       = ST_FETCH;
              idx_d         = '0;
              hpd_pending_d = 1'b0;
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = ST_FETCH;
          end
        end
      end
      ST_RETRY: begin
        state_d = ST_WRITE;
      end
      ST_DONE: begin
        if (start) begin
          state_d       = ST_RST_ASSERT;
          cnt_d         = '0;
          hpd_pending_d = 1'b0;
        end else if (hpd_evt || hpd_pending_q) begin
          state_d       = ST_FETCH;
          idx_d         = '0;
          hpd_pending_d = 1'b0;
        end
      end
      ST_ERROR: begin
        if (start) begin
          state_d       = ST_RST_ASSERT;
          cnt_d         = '0;
          hpd_pending_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    hdmi_tx_rst_n_d = !(state_d inside {ST_IDLE, ST_RST_ASSERT});
    i2c_req_d       = (state_d == ST_WRITE);
    video_en_d      = (state_d == ST_DONE);
    done_d          = (state_d == ST_DONE);
    error_d         = (state_d == ST_ERROR);
    busy_d          = (state_d inside {ST_RST_ASSERT, ST_PWRUP_WAIT, ST_FETCH,
                                       ST_LATCH, ST_WRITE, ST_RETRY});
    if (state_d == ST_FETCH) begin
      tbl_addr_d = idx_d;
    end
  end

  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      idx_q           <= '0;
      retry_q         <= '0;
      hpd_pending_q   <= 1'b0;
      hpd_meta_q      <= 1'b1;
      hpd_sync_q      <= 1'b1;
      hpd_prev_q      <= 1'b1;
      hdmi_tx_rst_n_q <= 1'b0;
      tbl_addr_q      <= '0;
      i2c_req_q       <= 1'b0;
      i2c_reg_q       <= '0;
      i2c_wdata_q     <= '0;
      video_en_q      <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      error_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      idx_q           <= idx_d;
      retry_q         <= retry_d;
      hpd_pending_q   <= hpd_pending_d;
      hpd_meta_q      <= hpd_meta_d;
      hpd_sync_q      <= hpd_sync_d;
      hpd_prev_q      <= hpd_prev_d;
      hdmi_tx_rst_n_q <= hdmi_tx_rst_n_d;
      tbl_addr_q      <= tbl_addr_d;
      i2c_req_q       <= i2c_req_d;
      i2c_reg_q       <= i2c_reg_d;
      i2c_wdata_q     <= i2c_wdata_d;
      video_en_q      <= video_en_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      error_q         <= error_d;
    end
  end

  assign hdmi_tx_rst_n = hdmi_tx_rst_n_q;
  assign tbl_addr      = tbl_addr_q;
  assign i2c_req       = i2c_req_q;
  assign i2c_dev_addr  = SLAVE_ADDR;
  assign i2c_reg       = i2c_reg_q;
  assign i2c_wdata     = i2c_wdata_q;
  assign video_en      = video_en_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;

endmodule
